// File: rtl/gba_window_pkg.sv
// gba_window_pkg: shared window types, screen limits and WININ/WINOUT field positions
package gba_window_pkg;
    typedef enum logic [1:0] {WSEL_WIN0, WSEL_WIN1, WSEL_OBJ, WSEL_OUT} win_sel_t;
    typedef logic [5:0] win_ctl_t;
    localparam int SCREEN_W       = 240;
    localparam int SCREEN_H       = 160;
    localparam int WININ_WIN0_LSB = 0;
    localparam int WININ_WIN1_LSB = 8;
    localparam int WINOUT_OUT_LSB = 0;
    localparam int WINOUT_OBJ_LSB = 8;
    localparam int CTL_EFF_BIT    = 5;
endpackage

// File: rtl/window_range_cmp.sv
// window_range_cmp: one-axis window membership lo <= p < hi_eff, where hi_eff clamps to MAX
// ports: lo/hi window edges, p pixel coordinate, hit membership result
module window_range_cmp #(
    parameter int MAX = 240
) (
    input  logic [7:0] lo,
    input  logic [7:0] hi,
    input  logic [7:0] p,
    output logic       hit
);
    logic [8:0] hi_eff;
    always_comb begin
        hi_eff = ({1'b0, hi} > 9'(MAX) || lo > hi) ? 9'(MAX) : {1'b0, hi};
        hit    = {1'b0, p} >= {1'b0, lo} && {1'b0, p} < hi_eff;
    end
endmodule

// File: rtl/window_mask_gen.sv
// window_mask_gen: per-pixel layer-enable mask and colour-effect enable from the GBA windows
// ports: clock/reset; frame_start, line_start, pixel_valid, obj_win strobes; dispcnt_win, win0h,
//        win1h, win0v, win1v, winin, winout registers; mask, effect_en, mask_valid (2-cycle latency)
module window_mask_gen
    import gba_window_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic        pixel_valid,
    input  logic        obj_win,
    input  logic [2:0]  dispcnt_win,
    input  logic [15:0] win0h,
    input  logic [15:0] win1h,
    input  logic [15:0] win0v,
    input  logic [15:0] win1v,
    input  logic [15:0] winin,
    input  logic [15:0] winout,
    output logic [4:0]  mask,
    output logic        effect_en,
    output logic        mask_valid
);
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic [2:0]  en_q, en_d;
    logic [15:0] w0h_q, w0h_d, w1h_q, w1h_d, w0v_q, w0v_d, w1v_q, w1v_d;
    win_ctl_t    c_w0_q, c_w0_d, c_w1_q, c_w1_d, c_out_q, c_out_d, c_obj_q, c_obj_d;
    logic        v1_q, v1_d, hit0_q, hit0_d, hit1_q, hit1_d, objh_q, objh_d, off_q, off_d;
    win_ctl_t    f_w0_q, f_w0_d, f_w1_q, f_w1_d, f_out_q, f_out_d, f_obj_q, f_obj_d;
    logic        v2_q, v2_d, eff_q, eff_d;
    logic [4:0]  mask_q, mask_d;
    logic        w0_hh, w0_vh, w1_hh, w1_vh;
    win_sel_t    sel;
    win_ctl_t    ctl;
    logic        unused_bits;

    assign unused_bits = ^{winin[15:14], winin[7:6], winout[15:14], winout[7:6]};

    window_range_cmp #(.MAX(SCREEN_W)) u_w0h (.lo(w0h_q[15:8]), .hi(w0h_q[7:0]), .p(x_q), .hit(w0_hh));
    window_range_cmp #(.MAX(SCREEN_H)) u_w0v (.lo(w0v_q[15:8]), .hi(w0v_q[7:0]), .p(y_q), .hit(w0_vh));
    window_range_cmp #(.MAX(SCREEN_W)) u_w1h (.lo(w1h_q[15:8]), .hi(w1h_q[7:0]), .p(x_q), .hit(w1_hh));
    window_range_cmp #(.MAX(SCREEN_H)) u_w1v (.lo(w1v_q[15:8]), .hi(w1v_q[7:0]), .p(y_q), .hit(w1_vh));

    always_comb begin
        y_d     = frame_start ? 8'd0 : line_start ? (y_q == 8'(SCREEN_H - 1) ? y_q : y_q + 8'd1) : y_q;
        x_d     = line_start ? 8'd0 : pixel_valid ? (x_q == 8'(SCREEN_W - 1) ? x_q : x_q + 8'd1) : x_q;
        en_d    = line_start ? dispcnt_win : en_q;
        w0h_d   = line_start ? win0h : w0h_q;
        w1h_d   = line_start ? win1h : w1h_q;
        w0v_d   = line_start ? win0v : w0v_q;
        w1v_d   = line_start ? win1v : w1v_q;
        c_w0_d  = line_start ? winin[WININ_WIN0_LSB +: 6] : c_w0_q;
        c_w1_d  = line_start ? winin[WININ_WIN1_LSB +: 6] : c_w1_q;
        c_out_d = line_start ? winout[WINOUT_OUT_LSB +: 6] : c_out_q;
        c_obj_d = line_start ? winout[WINOUT_OBJ_LSB +: 6] : c_obj_q;
        // S1 snapshots the hits and the control fields so a following line_start cannot alter them
        v1_d    = pixel_valid;
        hit0_d  = en_q[0] & w0_hh & w0_vh;
        hit1_d  = en_q[1] & w1_hh & w1_vh;
        objh_d  = en_q[2] & obj_win;
        off_d   = en_q == 3'b000;
        f_w0_d  = c_w0_q;
        f_w1_d  = c_w1_q;
        f_out_d = c_out_q;
        f_obj_d = c_obj_q;
        sel     = hit0_q ? WSEL_WIN0 : hit1_q ? WSEL_WIN1 : objh_q ? WSEL_OBJ : WSEL_OUT;
        ctl     = off_q ? 6'h3F : sel == WSEL_WIN0 ? f_w0_q : sel == WSEL_WIN1 ? f_w1_q :
                  sel == WSEL_OBJ ? f_obj_q : f_out_q;
        v2_d    = v1_q;
        mask_d  = v1_q ? ctl[4:0] : mask_q;
        eff_d   = v1_q ? ctl[CTL_EFF_BIT] : eff_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q <= '0; y_q <= '0; en_q <= '0;
            w0h_q <= '0; w1h_q <= '0; w0v_q <= '0; w1v_q <= '0;
            c_w0_q <= '0; c_w1_q <= '0; c_out_q <= '0; c_obj_q <= '0;
            v1_q <= 1'b0; hit0_q <= 1'b0; hit1_q <= 1'b0; objh_q <= 1'b0; off_q <= 1'b0;
            f_w0_q <= '0; f_w1_q <= '0; f_out_q <= '0; f_obj_q <= '0;
            v2_q <= 1'b0; mask_q <= 5'h1F; eff_q <= 1'b1;
        end else begin
            x_q <= x_d; y_q <= y_d; en_q <= en_d;
            w0h_q <= w0h_d; w1h_q <= w1h_d; w0v_q <= w0v_d; w1v_q <= w1v_d;
            c_w0_q <= c_w0_d; c_w1_q <= c_w1_d; c_out_q <= c_out_d; c_obj_q <= c_obj_d;
            v1_q <= v1_d; hit0_q <= hit0_d; hit1_q <= hit1_d; objh_q <= objh_d; off_q <= off_d;
            f_w0_q <= f_w0_d; f_w1_q <= f_w1_d; f_out_q <= f_out_d; f_obj_q <= f_obj_d;
            v2_q <= v2_d; mask_q <= mask_d; eff_q <= eff_d;
        end
    end

    assign mask       = mask_q;
    assign effect_en  = eff_q;
    assign mask_valid = v2_q;
endmodule

// File: tb/tb_window_mask_gen.sv
// tb_window_mask_gen: table-driven and sequence checks of window_mask_gen
module tb_window_mask_gen;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0, line_start = 1'b0, pixel_valid = 1'b0, obj_win = 1'b0;
    logic [2:0]  dispcnt_win = '0;
    logic [15:0] win0h = '0, win1h = '0, win0v = '0, win1v = '0, winin = '0, winout = '0;
    logic [4:0]  mask;
    logic        effect_en, mask_valid;
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [2:0]  dc;
        logic [15:0] w0h, w0v, w1h, w1v, wi, wo;
        int          y, x;
        logic        obj;
        logic [4:0]  m;
        logic        e;
    } vec_t;
    vec_t vecs[21];

    window_mask_gen dut (
        .clock(clock), .reset(reset), .frame_start(frame_start), .line_start(line_start),
        .pixel_valid(pixel_valid), .obj_win(obj_win), .dispcnt_win(dispcnt_win),
        .win0h(win0h), .win1h(win1h), .win0v(win0v), .win1v(win1v),
        .winin(winin), .winout(winout), .mask(mask), .effect_en(effect_en), .mask_valid(mask_valid)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic new_frame();
        frame_start = 1'b1; line_start = 1'b1; step();
        frame_start = 1'b0; line_start = 1'b0;
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) begin
            pixel_valid = 1'b1; obj_win = 1'b0; step();
        end
        pixel_valid = 1'b0; step(); step();
    endtask

    task automatic one_pixel(input string name, input logic o, input logic [4:0] m, input logic e);
        pixel_valid = 1'b1; obj_win = o; step();
        pixel_valid = 1'b0; obj_win = 1'b0;
        chk({name, ".early_valid"}, {7'd0, mask_valid}, 8'd0);
        step();
        chk({name, ".valid"}, {7'd0, mask_valid}, 8'd1);
        chk({name, ".mask"}, {3'd0, mask}, {3'd0, m});
        chk({name, ".eff"}, {7'd0, effect_en}, {7'd0, e});
    endtask

    initial begin
        vecs[0]  = '{3'b000, 16'h0A14, 16'h0510, 16'h0000, 16'h0000, 16'h0013, 16'h0000, 8, 15, 1'b1, 5'h1F, 1'b1};
        vecs[1]  = '{3'b001, 16'h0A14, 16'h0510, 16'h0000, 16'h0000, 16'h0013, 16'h0000, 8, 9, 1'b0, 5'h00, 1'b0};
        vecs[2]  = '{3'b001, 16'h0A14, 16'h0510, 16'h0000, 16'h0000, 16'h0013, 16'h0000, 8, 10, 1'b0, 5'h13, 1'b0};
        vecs[3]  = '{3'b001, 16'h0A14, 16'h0510, 16'h0000, 16'h0000, 16'h0013, 16'h0000, 8, 19, 1'b0, 5'h13, 1'b0};
        vecs[4]  = '{3'b001, 16'h0A14, 16'h0510, 16'h0000, 16'h0000, 16'h0013, 16'h0000, 8, 20, 1'b0, 5'h00, 1'b0};
        vecs[5]  = '{3'b001, 16'h0A14, 16'h0510, 16'h0000, 16'h0000, 16'h0013, 16'h0000, 4, 15, 1'b0, 5'h00, 1'b0};
        vecs[6]  = '{3'b001, 16'h0A14, 16'h0510, 16'h0000, 16'h0000, 16'h0013, 16'h0000, 5, 15, 1'b0, 5'h13, 1'b0};
        vecs[7]  = '{3'b001, 16'h0A14, 16'h0510, 16'h0000, 16'h0000, 16'h0013, 16'h0000, 16, 15, 1'b0, 5'h00, 1'b0};
        vecs[8]  = '{3'b011, 16'h0A14, 16'h0510, 16'h0C1E, 16'h0510, 16'h2113, 16'h0000, 8, 15, 1'b0, 5'h13, 1'b0};
        vecs[9]  = '{3'b011, 16'h0A14, 16'h0510, 16'h0C1E, 16'h0510, 16'h2113, 16'h0000, 8, 25, 1'b0, 5'h01, 1'b1};
        vecs[10] = '{3'b010, 16'h0A14, 16'h0510, 16'h0C1E, 16'h0510, 16'h2113, 16'h0000, 8, 15, 1'b0, 5'h01, 1'b1};
        vecs[11] = '{3'b001, 16'hF000, 16'h00A0, 16'h0000, 16'h0000, 16'h0013, 16'h0008, 8, 0, 1'b0, 5'h08, 1'b0};
        vecs[12] = '{3'b001, 16'hF000, 16'h00A0, 16'h0000, 16'h0000, 16'h0013, 16'h0008, 8, 239, 1'b0, 5'h08, 1'b0};
        vecs[13] = '{3'b001, 16'h00FA, 16'h00A0, 16'h0000, 16'h0000, 16'h0013, 16'h0008, 8, 0, 1'b0, 5'h13, 1'b0};
        vecs[14] = '{3'b001, 16'h00FA, 16'h00A0, 16'h0000, 16'h0000, 16'h0013, 16'h0008, 8, 239, 1'b0, 5'h13, 1'b0};
        vecs[15] = '{3'b001, 16'h3232, 16'h00A0, 16'h0000, 16'h0000, 16'h0013, 16'h0008, 8, 50, 1'b0, 5'h08, 1'b0};
        vecs[16] = '{3'b001, 16'h00EF, 16'h00A0, 16'h0000, 16'h0000, 16'h0013, 16'h0008, 8, 238, 1'b0, 5'h13, 1'b0};
        vecs[17] = '{3'b001, 16'h00EF, 16'h00A0, 16'h0000, 16'h0000, 16'h0013, 16'h0008, 8, 250, 1'b0, 5'h08, 1'b0};
        vecs[18] = '{3'b001, 16'h00FA, 16'h9FA0, 16'h0000, 16'h0000, 16'h0013, 16'h0008, 170, 5, 1'b0, 5'h13, 1'b0};
        vecs[19] = '{3'b001, 16'h00FA, 16'h9005, 16'h0000, 16'h0000, 16'h0013, 16'h0008, 8, 5, 1'b0, 5'h08, 1'b0};
        vecs[20] = '{3'b100, 16'h00FA, 16'h00A0, 16'h0000, 16'h0000, 16'h0013, 16'h1F04, 0, 3, 1'b1, 5'h1F, 1'b0};

        step(); step();
        chk("rst.valid", {7'd0, mask_valid}, 8'd0);
        chk("rst.mask", {3'd0, mask}, 8'h1F);
        chk("rst.eff", {7'd0, effect_en}, 8'd1);
        reset = 1'b0; step();
        one_pixel("nowin", 1'b0, 5'h1F, 1'b1);

        for (int v = 0; v < 21; v++) begin
            dispcnt_win = vecs[v].dc;
            win0h = vecs[v].w0h; win0v = vecs[v].w0v; win1h = vecs[v].w1h; win1v = vecs[v].w1v;
            winin = vecs[v].wi; winout = vecs[v].wo;
            new_frame();
            for (int i = 0; i < vecs[v].y; i++) begin
                line_start = 1'b1; step(); line_start = 1'b0;
            end
            pixels(vecs[v].x);
            one_pixel($sformatf("vec%0d", v), vecs[v].obj, vecs[v].m, vecs[v].e);
        end

        dispcnt_win = 3'b100; winout = 16'h1F04;
        new_frame();
        for (int i = 0; i < 8; i++) begin
            pixel_valid = i < 6; obj_win = i[0]; step();
            if (i >= 1 && i <= 6) begin
                chk($sformatf("objtog%0d.valid", i - 1), {7'd0, mask_valid}, 8'd1);
                chk($sformatf("objtog%0d.mask", i - 1), {3'd0, mask}, (i - 1) % 2 == 1 ? 8'h1F : 8'h04);
                chk($sformatf("objtog%0d.eff", i - 1), {7'd0, effect_en}, 8'd0);
            end
            if (i == 7) chk("objtog.tail_valid", {7'd0, mask_valid}, 8'd0);
        end
        pixel_valid = 1'b0; obj_win = 1'b0;

        dispcnt_win = 3'b001; win0h = 16'h0A14; win0v = 16'h00A0; winin = 16'h0013; winout = 16'h0000;
        new_frame();
        pixels(10);
        winin = 16'h001C;
        one_pixel("midline_old", 1'b0, 5'h13, 1'b0);
        line_start = 1'b1; step(); line_start = 1'b0;
        pixels(10);
        one_pixel("nextline_new", 1'b0, 5'h1C, 1'b0);

        winin = 16'h0013;
        line_start = 1'b1; step(); line_start = 1'b0;
        pixels(15);
        pixel_valid = 1'b1; step();
        pixel_valid = 1'b0; line_start = 1'b1; winin = 16'h0002; step();
        line_start = 1'b0;
        chk("inflight.valid", {7'd0, mask_valid}, 8'd1);
        chk("inflight.mask", {3'd0, mask}, 8'h13);
        step();

        winin = 16'h0013;
        line_start = 1'b1; step(); line_start = 1'b0;
        pixels(12);
        pixel_valid = 1'b1; step();
        reset = 1'b1; step();
        reset = 1'b0; pixel_valid = 1'b0; step();
        chk("midrst.valid0", {7'd0, mask_valid}, 8'd0);
        chk("midrst.mask", {3'd0, mask}, 8'h1F);
        chk("midrst.eff", {7'd0, effect_en}, 8'd1);
        step();
        chk("midrst.valid1", {7'd0, mask_valid}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
